// File: rtl/riscp_pkg.sv
// Shared definitions for the decode/issue slice: sizes, opcodes, instruction layout
// and small decode helpers.
package riscp_pkg;

    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int IW    = 32;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_STORE = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hF;

    // Field order mirrors the encoding: [31:28] opcode, [27:24] rd, [23:20] rs1,
    // [19:16] rs2, [15:0] imm.
    typedef struct packed {
        logic [3:0]    opcode;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [15:0]   imm;
    } instr_t;

    function automatic logic writes_rd(input instr_t i);
        return !(i.opcode inside {OP_STORE, OP_BEQ, OP_NOP}) && (i.rd != '0);
    endfunction

    function automatic logic [DW-1:0] sext_imm(input logic [15:0] imm);
        return {{(DW-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/scoreboard16.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by
// writeback or by a flush of the ID/EX instruction; r0 is never pending.
module scoreboard16
    import riscp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          fclr_en,
    input  logic [AW-1:0] fclr_idx,
    input  logic [AW-1:0] look1,
    input  logic [AW-1:0] look2,
    input  logic [AW-1:0] look3,
    output logic          hit1,
    output logic          hit2,
    output logic          hit3
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_next;

    always_comb begin
        // NOTE: start from a full default so every path assigns pend_next and no latch is inferred.
        pend_next = pending;
        if (clr_en)  pend_next[clr_idx]  = 1'b0;
        if (fclr_en) pend_next[fclr_idx] = 1'b0;
        // Applied last so a set beats a clear of the same register.
        if (set_en)  pend_next[set_idx]  = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: the vector is plain flops, not a RAM, so it is reset explicitly to avoid stale hazards.
        if (!rst_n) pending <= '0;
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        else        pending <= pend_next;
    end

    assign hit1 = pending[look1];
    assign hit2 = pending[look2];
    assign hit3 = pending[look3];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: holds one instruction in D, reads the register file, checks
// the pending-write scoreboard and moves the instruction into the ID/EX register.
module id_issue_stage
    import riscp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic [AW-1:0] read_reg1,
    output logic [AW-1:0] read_reg2,
    input  logic [DW-1:0] read_data1,
    input  logic [DW-1:0] read_data2,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_opcode,
    output logic [AW-1:0] out_rd,
    output logic          out_wr,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [DW-1:0] out_imm
);

    instr_t        d_instr;
    logic          d_valid;
    logic          d_nop;
    logic          d_wr;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic [AW-1:0] dst;
    logic          hit1;
    logic          hit2;
    logic          hit3;
    logic          hazard;
    logic          adv;

    // A NOP names no sources and a non-writer no destination; both map to r0, which never hits.
    assign d_nop  = (d_instr.opcode == OP_NOP);
    assign d_wr   = writes_rd(d_instr);
    assign src1   = d_nop ? '0 : d_instr.rs1;
    assign src2   = d_nop ? '0 : d_instr.rs2;
    assign dst    = d_wr  ? d_instr.rd : '0;

    assign hazard   = d_valid && (hit1 || hit2 || hit3);
    assign adv      = d_valid && !hazard && (!out_valid || out_ready) && !flush;
    assign in_ready = (!d_valid || adv) && !flush;

    assign read_reg1 = src1;
    assign read_reg2 = src2;

    scoreboard16 u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (adv && d_wr),
        .set_idx  (d_instr.rd),
        .clr_en   (wb_valid && (wb_rd != '0)),
        .clr_idx  (wb_rd),
        .fclr_en  (flush && out_valid && out_wr),
        .fclr_idx (out_rd),
        .look1    (src1),
        .look2    (src2),
        .look3    (dst),
        .hit1     (hit1),
        .hit2     (hit2),
        .hit3     (hit3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            d_valid <= 1'b1;
            d_instr <= instr_t'(in_instr);
        end else if (adv) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_wr     <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_imm    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (adv) begin
            out_valid  <= 1'b1;
            out_opcode <= d_instr.opcode;
            out_rd     <= d_instr.rd;
            out_wr     <= d_wr;
            out_op1    <= read_data1;
            out_op2    <= read_data2;
            out_imm    <= sext_imm(d_instr.imm);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: a register-file model feeds operands and
// a queue of expected ID/EX contents is compared on every output handshake.
module tb_id_issue_stage;
    import riscp_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_opcode;
    logic [AW-1:0] out_rd;
    logic          out_wr;
    logic [DW-1:0] out_op1;
    logic [DW-1:0] out_op2;
    logic [DW-1:0] out_imm;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_wr     (out_wr),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_imm    (out_imm)
    );

    logic [DW-1:0] rf [NREGS];
    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];

    typedef struct {
        logic [3:0]    opcode;
        logic [AW-1:0] rd;
        logic          wr;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] imm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   num_checks = 0;
    int   num_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [3:0] op;
        logic nop;
        op     = ins[31:28];
        nop    = (op == 4'hF);
        e.opcode = op;
        e.rd   = ins[27:24];
        e.wr   = (op != 4'hC) && (op != 4'hD) && (op != 4'hF) && (ins[27:24] != 4'd0);
        e.op1  = nop ? rf[0] : rf[ins[23:20]];
        e.op2  = nop ? rf[0] : rf[ins[19:16]];
        e.imm  = {{16{ins[15]}}, ins[15:0]};
        return e;
    endfunction

    // Output monitor and input recorder share one sampling point between edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_opcode", {28'd0, out_opcode}, {28'd0, mon_e.opcode});
                        check("sb_rd",     {28'd0, out_rd},     {28'd0, mon_e.rd});
                        check("sb_wr",     {31'd0, out_wr},     {31'd0, mon_e.wr});
                        check("sb_op1",    out_op1,             mon_e.op1);
                        check("sb_op2",    out_op2,             mon_e.op2);
                        check("sb_imm",    out_imm,             mon_e.imm);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_instr));
            end
        end
    end

    task automatic send(input logic [31:0] ins, output int waits);
        in_valid = 1'b1;
        in_instr = ins;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    function automatic logic [31:0] pend(input int r);
        return {31'd0, dut.u_sb.pending[r]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, w1, w2, w3, w4, w5;

        rf[0] = '0;
        rf[1] = 32'h0005_671E;
        rf[2] = 32'h0009_8AAA;
        for (int i = 3; i < NREGS; i++) rf[i] = (i * 32'h0101_0101) ^ 32'h5A00_0000;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; wb_valid = 1'b0; wb_rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        cycles(3);
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_read_reg1", {28'd0, read_reg1}, 32'd0);
        check("rst_read_reg2", {28'd0, read_reg2}, 32'd0);
        check("rst_out_op1",   out_op1, 32'd0);
        check("rst_out_imm",   out_imm, 32'd0);
        check("rst_pending",   {16'd0, dut.u_sb.pending}, 32'd0);
        @(posedge clk); #1;

        // Single ADD r3 = r1, r2 with a negative immediate.
        send(mk(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h8001), w);
        in_valid = 1'b0;
        check("t1_wait", w, 0);
        @(negedge clk);
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_op1", out_op1, 32'h0005_671E);
        check("t1_op2", out_op2, 32'h0009_8AAA);
        check("t1_rd",  {28'd0, out_rd}, 32'd3);
        check("t1_wr",  {31'd0, out_wr}, 32'd1);
        check("t1_imm", out_imm, 32'hFFFF_8001);
        check("t1_pend3_set", pend(3), 32'd1);
        @(posedge clk); #1;
        wb(4'd3);
        @(negedge clk);
        check("t1_pend3_clr", pend(3), 32'd0);
        @(posedge clk); #1;

        // Back-to-back independent instructions.
        send(mk(OP_ADD, 4'd4, 4'd1, 4'd2, 16'h0010), w1);
        send(mk(OP_ADD, 4'd5, 4'd2, 4'd1, 16'h0020), w2);
        in_valid = 1'b0;
        check("t2_wait_a", w1, 0);
        check("t2_wait_b", w2, 0);
        cycles(3);
        check("t2_drain", exp_q.size(), 0);
        wb(4'd5);

        // RAW on r4: SUB stalls until r4 is written back.
        send(mk(OP_SUB, 4'd8, 4'd4, 4'd2, 16'h0000), w);
        check("t3_sub_accept", w, 0);
        in_valid = 1'b1;
        in_instr = mk(OP_ADD, 4'd9, 4'd1, 4'd2, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", {31'd0, in_ready},  32'd0);
            check("t3_stall_out",   {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 4'd4;
        @(negedge clk);
        check("t3_wb_cycle_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("t3_after_wb_ready", {31'd0, in_ready},  32'd1);
        check("t3_after_wb_out",   {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_sub_issued", {31'd0, out_valid}, 32'd1);
        check("t3_sub_opcode", {28'd0, out_opcode}, {28'd0, OP_SUB});
        @(posedge clk); #1;
        cycles(2);
        check("t3_drain", exp_q.size(), 0);
        wb(4'd8);
        wb(4'd9);

        // Backpressure with both D and OUT occupied.
        out_ready = 1'b0;
        send(mk(OP_ADD, 4'd10, 4'd1, 4'd2, 16'h0100), w1);
        send(mk(OP_XOR, 4'd11, 4'd3, 4'd4, 16'h0200), w2);
        in_valid = 1'b0;
        check("t4_second_accept", w2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_rd",    {28'd0, out_rd},    32'd10);
            check("t4_hold_op2",   out_op2,            32'h0009_8AAA);
            check("t4_hold_ready", {31'd0, in_ready},  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        cycles(3);
        check("t4_drain", exp_q.size(), 0);
        wb(4'd10);
        wb(4'd11);

        // Flush while OUT holds a writer of r6.
        out_ready = 1'b0;
        send(mk(OP_ADD, 4'd6, 4'd1, 4'd2, 16'h0006), w);
        in_valid = 1'b0;
        cycles(1);
        @(negedge clk);
        check("t5_out_before", {31'd0, out_valid}, 32'd1);
        check("t5_pend6_set",  pend(6), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5_out_killed", {31'd0, out_valid}, 32'd0);
        check("t5_pend6_clr",  pend(6), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk(OP_SUB, 4'd12, 4'd6, 4'd2, 16'h0000), w);
        in_valid = 1'b0;
        check("t5_accept", w, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_no_stall", {31'd0, out_valid}, 32'd1);
        check("t5_rd12",     {28'd0, out_rd},    32'd12);
        @(posedge clk); #1;
        wb(4'd12);

        // Issue of r7 and writeback of r7 on the same edge: the set wins.
        send(mk(OP_ADD, 4'd7, 4'd1, 4'd2, 16'h0007), w);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 4'd7;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("t6_pend7_wins", pend(7), 32'd1);
        @(posedge clk); #1;
        wb(4'd7);

        // NOP, rd=0 and STORE never stall even with their fields naming a pending register.
        send(mk(OP_ADD,   4'd13, 4'd1,  4'd2,  16'h000D), w1);
        send(mk(OP_NOP,   4'd13, 4'd13, 4'd13, 16'hFFFF), w2);
        send(mk(OP_ADD,   4'd0,  4'd1,  4'd2,  16'h1234), w3);
        send(mk(OP_STORE, 4'd13, 4'd1,  4'd2,  16'h7FFF), w4);
        send(mk(OP_AND,   4'd14, 4'd2,  4'd1,  16'h0000), w5);
        in_valid = 1'b0;
        check("t6_nop_wait",   w2, 0);
        check("t6_rd0_wait",   w3, 0);
        check("t6_store_wait", w4, 0);
        check("t6_tail_wait",  w5, 0);
        cycles(3);
        check("t6_pend13", pend(13), 32'd1);
        check("t6_pend0",  pend(0),  32'd0);
        check("t6_drain",  exp_q.size(), 0);
        wb(4'd13);
        wb(4'd14);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage directly upstream of the 16x32 register file.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and drives the register-file read addresses.
- Captures the returned operands into an ID/EX output register for execute.
- Keeps a per-register pending-write scoreboard, cleared by writeback, and stalls on RAW/WAW hazards. Supports a flush from branch resolution.

Parameters:
- NREGS, 16, number of architectural registers
- AW, 4, register address width (log2 NREGS)
- DW, 32, data width
- IW, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  fetch has an instruction
- in_instr  in  IW  instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm
- in_ready  out  1  stage can accept
- read_reg1  out  AW  to register file, = rs1 of held instruction
- read_reg2  out  AW  to register file, = rs2 of held instruction
- read_data1  in  DW  combinational read data from register file
- read_data2  in  DW  combinational read data from register file
- wb_valid  in  1  writeback retiring a register write this cycle
- wb_rd  in  AW  register being written back
- flush  in  1  kill all instructions held in this stage
- out_valid  out  1  ID/EX register holds an issued instruction
- out_ready  in  1  execute accepts
- out_opcode  out  4  opcode
- out_rd  out  AW  destination
- out_wr  out  1  instruction writes rd
- out_op1  out  DW  rs1 operand
- out_op2  out  DW  rs2 operand
- out_imm  out  DW  sign-extended imm

Behaviour:
- Reset (rst_n=0 at an edge):
  - d_valid=0, out_valid=0, pending=0.
  - All out_* data = 0; read_reg1/2 = 0.
  - in_ready=1 from the first cycle after reset.
- Two internal registers:
  - D: held instruction plus d_valid.
  - OUT: ID/EX register.
- Decode rules:
  - wr = (opcode not in {0xC STORE, 0xD BEQ, 0xF NOP}) and rd != 0.
  - NOP reads no sources.
  - A source or destination equal to r0 never causes a hazard.
- Hazard:
  - hazard = d_valid and (pending[rs1] or pending[rs2] or (wr and pending[rd])), using the registered pending vector only; there is no same-cycle writeback bypass.
  - A stalled instruction issues at the earliest one cycle after its wb clear.
- Advance:
  - adv = d_valid and !hazard and (!out_valid or out_ready) and !flush.
  - in_ready = !d_valid or adv. This is a combinational path through out_ready.
- Transfer timing:
  - Instruction accepted at edge N appears on OUT at edge N+1 at the earliest.
  - Throughput is one instruction per cycle with no hazards.
- On adv:
  - OUT captures the opcode, rd, wr, read_data1/2 and the sign-extended imm.
  - pending[rd] is set if wr.
- Output hold: OUT is stable while out_valid and !out_ready. It drops to 0 after a handshake if no advance occurs.
- Scoreboard:
  - wb_valid and wb_rd != 0 clears pending[wb_rd].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - pending[0] is always 0.
- Flush (highest priority after reset):
  - Next edge: d_valid=0, out_valid=0.
  - If out_valid and out_wr, pending[out_rd] is cleared; wb clears still apply.
  - in_ready=0 in the flush cycle. Fetch must re-present the instruction afterwards.
- Reset mid-operation: discards everything with no writeback interaction. Writeback must also be reset.
- Boundaries:
  - A full stall (D valid, OUT valid, !out_ready) deasserts in_ready.
  - A 4-bit index covers all 16 registers; there is no wrap-around beyond that.

Decomposition:
- Shared package riscp_pkg:
  - opcode constants (OP_STORE=4'hC, OP_BEQ=4'hD, OP_NOP=4'hF, etc.)
  - instruction field bit positions
  - AW/DW constants
- One natural sub-module, scoreboard16. It holds the pending vector with set/clear/flush-clear ports and a 3-port hazard lookup.

Test Plan:
- Reset, then in_valid with ADD rd=3, rs1=1, rs2=2, out_ready=1 -> out_valid at the next edge; op1=0x0005671E, op2=0x00098AAA, out_rd=3, out_wr=1.
- Back-to-back independent ADDs (rd=4, rd=5) -> one out_valid per cycle, in_ready held at 1.
- RAW: ADD rd=4, then SUB rs1=4 -> SUB held, in_ready=0; SUB issues exactly one cycle after wb_valid with wb_rd=4.
- Backpressure: out_ready=0 for 3 cycles with D full -> out_* stable, in_ready=0; releases in order.
- Flush with an OUT instruction writing rd=6 -> out_valid=0 next cycle, pending[6]=0, and a following instruction reading r6 issues without stall.
- Same-cycle issue of rd=7 and wb_valid with wb_rd=7 -> pending[7]=1 afterwards. An instruction with rd=0 or NOP never stalls.
